dma_m1: RTL and testbench
=========================

Name: dma_m1

Overview:
- Word-copy bus master that drives the second master port (m1) of the system bus `sb`.
- Copies LEN 32-bit words from SRC to DST through `sb`, sharing data memory with the core on m0.
- Control is a simple start/busy/done strobe interface driven by the SoC top level.
- `sb` arbitrates between the core and this block; this block waits on m1_gnt whenever the core holds the bus.

Parameters:
- LEN_W, 16, width of the word-count input.
- BYTE_MASK_WORD, 4'b1111, value driven on m1_byte_mask_o for full-word accesses.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- start  input  1  one-cycle request; sampled only in IDLE
- abort  input  1  cancel transfer; returns to IDLE next edge
- src_addr  input  32  source byte address; bits[1:0] ignored
- dst_addr  input  32  destination byte address; bits[1:0] ignored
- len  input  LEN_W  number of words to copy
- busy_o  output  1  high while not in IDLE
- done_o  output  1  one-cycle pulse on normal completion
- m1_un_sign_o  output  1  constant `UNSIGNED
- m1_byte_mask_o  output  4  BYTE_MASK_WORD during an access, `SL_NONE otherwise
- m1_re_o  output  1  read request
- m1_we_o  output  1  write request
- m1_addr_o  output  32  access address
- m1_wdata_o  output  32  write data
- m1_rdata  input  32  read data from sb
- m1_gnt  input  1  sb serves m1 this cycle

Behaviour:
- Reset: asynchronous; all outputs 0 except m1_un_sign_o=`UNSIGNED and m1_byte_mask_o=`SL_NONE. State=IDLE; internal src/dst/count/data registers are cleared.
- States:
  - IDLE
    - start=1 and len!=0: latch {src[31:2],2'b00}, {dst[31:2],2'b00} and len; go to RD_REQ.
    - start=1 and len=0: go to DONE.
    - start=0: stay in IDLE.
  - RD_REQ: drive re=1 and addr=src. If m1_gnt=1, go to RD_WAIT; otherwise hold the request unchanged.
  - RD_WAIT: no request driven. Capture m1_rdata into the data register; go to WR_REQ. Read data is valid exactly one cycle after a granted read.
  - WR_REQ: drive we=1, addr=dst and wdata=data register. If m1_gnt=1:
    - src+=4, dst+=4, count-=1.
    - If new count==0, go to DONE; otherwise go to RD_REQ.
    - If m1_gnt=0, hold the request unchanged.
  - DONE: done_o=1 for one cycle; go to IDLE.
- Never assert re and we together.
- Throughput: 3 cycles per word with continuous grant. start sampled at edge k gives done_o high in cycle k+1+3·len.
- Address arithmetic is modulo 2^32; 0xFFFF_FFFC+4 wraps to 0.
- start while busy_o=1 is ignored.
- abort:
  - Has priority over all transitions in any non-IDLE state; next state is IDLE and no done pulse is produced.
  - A write already granted in the same cycle as abort completes on the bus; nothing further is issued.
  - abort in IDLE has no effect.
- start and abort in the same IDLE cycle: start wins.
- busy_o is 1 in RD_REQ, RD_WAIT, WR_REQ and DONE.

Optional Feature:
- DMA_FILL_EN defined:
  - Adds input fill_mode (1) and input fill_data (32).
  - When fill_mode is latched as 1 at start, RD_REQ and RD_WAIT are skipped. The block goes IDLE→WR_REQ, writes fill_data to LEN words starting at DST, and src is unused.
  - Throughput is 1 cycle per word with continuous grant.
- DMA_FILL_EN not defined: ports absent; copy-only behaviour as above.

Test Plan:
- Copy 4 words, src=0x100, dst=0x200, m1_gnt tied 1, memory preloaded with 0x11,0x22,0x33,0x44 → dst words equal the source; done_o pulses at k+13; exactly 4 re and 4 we grants.
- len=0 with start → done_o in cycle k+1; m1_re_o/m1_we_o never assert.
- m1_gnt low for 5 cycles during RD_REQ and 3 cycles during WR_REQ → request, address and data stay stable while waiting; copy still correct; done_o delayed by 8 cycles.
- src=0xFFFF_FFFC, len=2 → second read at address 0x0000_0000; src bits[1:0]=2'b11 are ignored.
- Abort in RD_WAIT of word 2 of 4 → back to IDLE next cycle, no done_o, only word 1 written. A new start is then accepted.
- Reset asserted mid-WR_REQ → all outputs return to reset values immediately, without waiting for a clock edge.
- (DMA_FILL_EN) fill_mode=1, fill_data=0xDEADBEEF, len=3 → 3 writes on consecutive cycles, no reads, done_o at k+4.

Source files
------------

// File: rtl/dma_m1_if.sv
// dma_m1_if: m1 port bundle between the word-copy DMA master and the
// system bus arbiter.
//   m1_un_sign_o   - load sign mode (always unsigned for this master)
//   m1_byte_mask_o - byte lanes of the access (none when idle)
//   m1_re_o/we_o   - read / write request, never both at once
//   m1_addr_o      - word-aligned access address
//   m1_wdata_o     - write data
//   m1_rdata       - read data, valid the cycle after a granted read
//   m1_gnt         - arbiter serves m1 this cycle
interface dma_m1_if;
   logic        m1_un_sign_o;
   logic [3:0]  m1_byte_mask_o;
   logic        m1_re_o;
   logic        m1_we_o;
   logic [31:0] m1_addr_o;
   logic [31:0] m1_wdata_o;
   logic [31:0] m1_rdata;
   logic        m1_gnt;

   modport master (
      output m1_un_sign_o, m1_byte_mask_o, m1_re_o, m1_we_o, m1_addr_o, m1_wdata_o,
      input  m1_rdata, m1_gnt
   );

   modport slave (
      input  m1_un_sign_o, m1_byte_mask_o, m1_re_o, m1_we_o, m1_addr_o, m1_wdata_o,
      output m1_rdata, m1_gnt
   );
endinterface

// File: rtl/dma_m1.sv
// dma_m1: word-copy bus master on system-bus port m1.
// Copies len 32-bit words from src_addr to dst_addr, one read then one
// write per word, stalling on m1_gnt while the core owns the bus.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   start, abort        - start request (IDLE only), cancel transfer
//   src_addr, dst_addr  - byte addresses, low two bits dropped
//   len                 - word count (0 completes immediately)
//   busy_o, done_o      - not-idle flag, one-cycle completion pulse
//   m1                  - bus master port (dma_m1_if.master)
// Optional build macro DMA_FILL_EN adds fill_mode/fill_data: a latched
// fill_mode skips the reads and writes fill_data to every word at dst.
`ifndef UNSIGNED
`define UNSIGNED 1'b1
`endif
`ifndef SL_NONE
`define SL_NONE 4'b0000
`endif

module dma_m1 #(
   parameter int         LEN_W          = 16,
   parameter logic [3:0] BYTE_MASK_WORD = 4'b1111
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [31:0]      src_addr,
   input  logic [31:0]      dst_addr,
   input  logic [LEN_W-1:0] len,
`ifdef DMA_FILL_EN
   input  logic             fill_mode,
   input  logic [31:0]      fill_data,
`endif
   output logic             busy_o,
   output logic             done_o,
   dma_m1_if.master         m1
);

   typedef enum logic [2:0] {S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_DONE} state_t;

   state_t           r_state, w_next;
   logic [31:0]      r_src, r_dst, r_data;
   logic [LEN_W-1:0] r_count;
   logic             r_fill;
   logic             w_fill_in;
   logic [31:0]      w_fill_data;
   logic             w_re, w_we;
   logic             w_unused;

`ifdef DMA_FILL_EN
   assign w_fill_in   = fill_mode;
   assign w_fill_data = fill_data;
`else
   assign w_fill_in   = 1'b0;
   assign w_fill_data = '0;
`endif

   // address bits [1:0] are dropped on latch
   assign w_unused = ^{src_addr[1:0], dst_addr[1:0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_src   <= '0;
         r_dst   <= '0;
         r_data  <= '0;
         r_count <= '0;
         r_fill  <= 1'b0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: if (start && len != '0) begin
               r_src   <= {src_addr[31:2], 2'b00};
               r_dst   <= {dst_addr[31:2], 2'b00};
               r_count <= len;
               r_fill  <= w_fill_in;
               if (w_fill_in) r_data <= w_fill_data;
            end
            S_RD_WAIT: r_data <= m1.m1_rdata;
            S_WR_REQ: if (m1.m1_gnt) begin
               // 32-bit adds wrap naturally past 0xFFFF_FFFC
               r_src   <= r_src + 32'd4;
               r_dst   <= r_dst + 32'd4;
               r_count <= r_count - LEN_W'(1);
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (start) w_next = (len == '0) ? S_DONE :
                                        (w_fill_in ? S_WR_REQ : S_RD_REQ);
         S_RD_REQ:  if (m1.m1_gnt) w_next = S_RD_WAIT;
         S_RD_WAIT: w_next = S_WR_REQ;
         S_WR_REQ:  if (m1.m1_gnt) w_next = (r_count == LEN_W'(1)) ? S_DONE :
                                             (r_fill ? S_WR_REQ : S_RD_REQ);
         S_DONE:    w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
      // abort overrides every transition once a transfer is under way
      if (abort && r_state != S_IDLE) w_next = S_IDLE;
   end

   assign w_re = (r_state == S_RD_REQ);
   assign w_we = (r_state == S_WR_REQ);

   assign busy_o = (r_state != S_IDLE);
   // an abort landing in DONE suppresses the pulse
   assign done_o = (r_state == S_DONE) && !abort;

   assign m1.m1_un_sign_o   = `UNSIGNED;
   assign m1.m1_byte_mask_o = (w_re || w_we) ? BYTE_MASK_WORD : `SL_NONE;
   assign m1.m1_re_o        = w_re;
   assign m1.m1_we_o        = w_we;
   assign m1.m1_addr_o      = w_re ? r_src : (w_we ? r_dst : 32'd0);
   assign m1.m1_wdata_o     = w_we ? r_data : 32'd0;

endmodule

// File: tb/tb_dma_m1.sv
module tb_dma_m1;
   logic        clk = 1'b0;
   logic        rst;
   logic        start, abort;
   logic [31:0] src_addr, dst_addr;
   logic [15:0] len;
   logic        busy_o, done_o;
`ifdef DMA_FILL_EN
   logic        fill_mode;
   logic [31:0] fill_data;
`endif

   dma_m1_if bus();

   dma_m1 dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
`ifdef DMA_FILL_EN
      .fill_mode(fill_mode), .fill_data(fill_data),
`endif
      .busy_o(busy_o), .done_o(done_o), .m1(bus)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // bus model: reads from smem (preloaded by the bench), writes land in dmem
   logic [31:0] smem [256];
   logic [31:0] dmem [256];
   logic [31:0] rd_log [16];
   int nre = 0, nwe = 0, rec = 0, wec = 0, ndone = 0, overlap = 0;

   always @(posedge clk) begin
      if (bus.m1_re_o && bus.m1_gnt) begin
         bus.m1_rdata     <= smem[bus.m1_addr_o[9:2]];
         rd_log[nre % 16] <= bus.m1_addr_o;
         nre              <= nre + 1;
      end
      if (bus.m1_we_o && bus.m1_gnt) begin
         dmem[bus.m1_addr_o[9:2]] <= bus.m1_wdata_o;
         nwe                      <= nwe + 1;
      end
      if (bus.m1_re_o) rec <= rec + 1;
      if (bus.m1_we_o) wec <= wec + 1;
      if (bus.m1_re_o && bus.m1_we_o) overlap <= overlap + 1;
      if (done_o) ndone <= ndone + 1;
   end

   // grant model: withhold m1_gnt until the stall counters reach their targets;
   // while withheld the request must not move
   int rd_cnt = 0, rd_tgt = 0, wr_cnt = 0, wr_tgt = 0, stab_err = 0;
   logic         held_v = 1'b0;
   logic [65:0]  held;
   always @(negedge clk) begin
      bus.m1_gnt <= !((bus.m1_re_o && rd_cnt < rd_tgt) || (bus.m1_we_o && wr_cnt < wr_tgt));
      if (bus.m1_re_o && rd_cnt < rd_tgt) rd_cnt <= rd_cnt + 1;
      if (bus.m1_we_o && wr_cnt < wr_tgt) wr_cnt <= wr_cnt + 1;
      if (held_v && {bus.m1_re_o, bus.m1_we_o, bus.m1_addr_o, bus.m1_wdata_o} !== held)
         stab_err <= stab_err + 1;
      held_v <= (bus.m1_re_o && rd_cnt < rd_tgt) || (bus.m1_we_o && wr_cnt < wr_tgt);
      held   <= {bus.m1_re_o, bus.m1_we_o, bus.m1_addr_o, bus.m1_wdata_o};
   end

   task automatic issue(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
      @(negedge clk);
      src_addr = s; dst_addr = d; len = l; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // edges after the sampling edge until done_o is seen high
   task automatic wait_done(output int n);
      n = 0;
      while (done_o !== 1'b1 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 200) begin
         tests++; fails++;
         $display("FAIL done_timeout: done_o never rose within %0d cycles", n);
      end
   endtask

   task automatic test_reset;
      tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", busy_o); end
      tests++; if (done_o !== 1'b0) begin fails++; $display("FAIL rst_done: got %b want 0", done_o); end
      tests++; if (bus.m1_re_o !== 1'b0 || bus.m1_we_o !== 1'b0) begin fails++;
         $display("FAIL rst_req: got re=%b we=%b want 0 0", bus.m1_re_o, bus.m1_we_o); end
      tests++; if (bus.m1_addr_o !== 32'd0 || bus.m1_wdata_o !== 32'd0) begin fails++;
         $display("FAIL rst_addr_data: got %h %h want 0 0", bus.m1_addr_o, bus.m1_wdata_o); end
      tests++; if (bus.m1_byte_mask_o !== 4'b0000) begin fails++;
         $display("FAIL rst_mask: got %b want 0000", bus.m1_byte_mask_o); end
      tests++; if (bus.m1_un_sign_o !== 1'b1) begin fails++;
         $display("FAIL rst_unsign: got %b want 1", bus.m1_un_sign_o); end
   endtask

   task automatic test_copy;
      int n, b_re, b_we, b_dn;
      b_re = nre; b_we = nwe; b_dn = ndone;
      issue(32'h100, 32'h200, 16'd4);
      #2;
      tests++; if (bus.m1_re_o !== 1'b1 || bus.m1_addr_o !== 32'h100 || bus.m1_byte_mask_o !== 4'b1111) begin
         fails++; $display("FAIL copy_first_req: got re=%b addr=%h mask=%b want 1 100 1111",
                           bus.m1_re_o, bus.m1_addr_o, bus.m1_byte_mask_o); end
      wait_done(n);
      tests++; if (n !== 12) begin fails++; $display("FAIL copy_latency: got %0d want 12", n); end
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
         tests++; if (dmem[8'h80 + i] !== 32'h11 * (i + 1)) begin fails++;
            $display("FAIL copy_word%0d: got %h want %h", i, dmem[8'h80 + i], 32'h11 * (i + 1)); end
      end
      tests++; if (nre - b_re !== 4 || nwe - b_we !== 4) begin fails++;
         $display("FAIL copy_grants: got rd=%0d wr=%0d want 4 4", nre - b_re, nwe - b_we); end
      tests++; if (ndone - b_dn !== 1) begin fails++; $display("FAIL copy_done_pulses: got %0d want 1", ndone - b_dn); end
      tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL copy_idle: busy got %b want 0", busy_o); end
   endtask

   task automatic test_len0;
      int n, b_rc, b_wc;
      b_rc = rec; b_wc = wec;
      issue(32'h100, 32'h200, 16'd0);
      tests++; if (busy_o !== 1'b1) begin fails++; $display("FAIL len0_busy: got %b want 1", busy_o); end
      wait_done(n);
      tests++; if (n !== 0) begin fails++; $display("FAIL len0_latency: got %0d want 0", n); end
      repeat (3) @(posedge clk); #1;
      tests++; if (rec !== b_rc || wec !== b_wc) begin fails++;
         $display("FAIL len0_no_req: got re_cycles=%0d we_cycles=%0d want 0 0", rec - b_rc, wec - b_wc); end
   endtask

   task automatic test_stall;
      int n;
      rd_tgt = rd_cnt + 5;
      wr_tgt = wr_cnt + 3;
      issue(32'h300, 32'h340, 16'd2);
      wait_done(n);
      tests++; if (n !== 14) begin fails++; $display("FAIL stall_latency: got %0d want 14", n); end
      tests++; if (rd_cnt !== rd_tgt || wr_cnt !== wr_tgt) begin fails++;
         $display("FAIL stall_applied: got rd=%0d wr=%0d want %0d %0d", rd_cnt, wr_cnt, rd_tgt, wr_tgt); end
      tests++; if (stab_err !== 0) begin fails++; $display("FAIL stall_stable: got %0d changes want 0", stab_err); end
      @(posedge clk); #1;
      tests++; if (dmem[8'hD0] !== 32'hA1 || dmem[8'hD1] !== 32'hA2) begin fails++;
         $display("FAIL stall_data: got %h %h want a1 a2", dmem[8'hD0], dmem[8'hD1]); end
   endtask

   task automatic test_wrap;
      int n, base;
      base = nre;
      issue(32'hFFFF_FFFF, 32'h0C0, 16'd2);
      wait_done(n);
      tests++; if (n !== 6) begin fails++; $display("FAIL wrap_latency: got %0d want 6", n); end
      tests++; if (rd_log[base % 16] !== 32'hFFFF_FFFC) begin fails++;
         $display("FAIL wrap_rd0: got %h want fffffffc", rd_log[base % 16]); end
      tests++; if (rd_log[(base + 1) % 16] !== 32'h0) begin fails++;
         $display("FAIL wrap_rd1: got %h want 00000000", rd_log[(base + 1) % 16]); end
      @(posedge clk); #1;
      tests++; if (dmem[8'h30] !== 32'hCAFE0001 || dmem[8'h31] !== 32'hCAFE0002) begin fails++;
         $display("FAIL wrap_data: got %h %h want cafe0001 cafe0002", dmem[8'h30], dmem[8'h31]); end
   endtask

   task automatic test_abort;
      int n, b_dn, b_we;
      b_dn = ndone; b_we = nwe;
      issue(32'h280, 32'h2C0, 16'd4);
      repeat (4) @(posedge clk); #1;   // RD_WAIT of word 2
      tests++; if (busy_o !== 1'b1 || bus.m1_re_o !== 1'b0 || bus.m1_we_o !== 1'b0) begin fails++;
         $display("FAIL abort_pre: got busy=%b re=%b we=%b want 1 0 0", busy_o, bus.m1_re_o, bus.m1_we_o); end
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL abort_idle: busy got %b want 0", busy_o); end
      repeat (5) @(posedge clk); #1;
      tests++; if (ndone !== b_dn) begin fails++; $display("FAIL abort_no_done: got %0d pulses want 0", ndone - b_dn); end
      tests++; if (nwe - b_we !== 1 || dmem[8'hB0] !== 32'h5A5A0001) begin fails++;
         $display("FAIL abort_written: got writes=%0d word=%h want 1 5a5a0001", nwe - b_we, dmem[8'hB0]); end
      issue(32'h284, 32'h2C4, 16'd1);
      wait_done(n);
      tests++; if (n !== 3) begin fails++; $display("FAIL abort_restart_latency: got %0d want 3", n); end
      @(posedge clk); #1;
      tests++; if (dmem[8'hB1] !== 32'h5A5A0002) begin fails++;
         $display("FAIL abort_restart_data: got %h want 5a5a0002", dmem[8'hB1]); end
   endtask

   task automatic test_reset_mid;
      issue(32'h100, 32'h3F0, 16'd2);
      repeat (2) @(posedge clk); #1;
      tests++; if (bus.m1_we_o !== 1'b1 || bus.m1_addr_o !== 32'h3F0) begin fails++;
         $display("FAIL midrst_pre: got we=%b addr=%h want 1 3f0", bus.m1_we_o, bus.m1_addr_o); end
      #2 rst = 1'b1;
      #1;
      test_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

`ifdef DMA_FILL_EN
   task automatic test_fill;
      int n, b_rc, b_we;
      b_rc = rec; b_we = nwe;
      fill_mode = 1'b1; fill_data = 32'hDEADBEEF;
      issue(32'h0, 32'h380, 16'd3);
      fill_mode = 1'b0;
      wait_done(n);
      tests++; if (n !== 3) begin fails++; $display("FAIL fill_latency: got %0d want 3", n); end
      @(posedge clk); #1;
      tests++; if (rec !== b_rc || nwe - b_we !== 3) begin fails++;
         $display("FAIL fill_bus: got re_cycles=%0d writes=%0d want 0 3", rec - b_rc, nwe - b_we); end
      for (int i = 0; i < 3; i++) begin
         tests++; if (dmem[8'hE0 + i] !== 32'hDEADBEEF) begin fails++;
            $display("FAIL fill_word%0d: got %h want deadbeef", i, dmem[8'hE0 + i]); end
      end
   endtask
`endif

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      src_addr = '0; dst_addr = '0; len = '0;
`ifdef DMA_FILL_EN
      fill_mode = 1'b0; fill_data = '0;
`endif
      for (int i = 0; i < 256; i++) smem[i] = 32'h0;
      for (int i = 0; i < 4; i++) smem[8'h40 + i] = 32'h11 * (i + 1);
      smem[8'hC0] = 32'hA1; smem[8'hC1] = 32'hA2;
      smem[8'hFF] = 32'hCAFE0001; smem[8'h00] = 32'hCAFE0002;
      for (int i = 0; i < 4; i++) smem[8'hA0 + i] = 32'h5A5A0001 + i;
      repeat (3) @(posedge clk); #1;
      test_reset();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      test_reset();
      test_copy();
      test_len0();
      test_stall();
      test_wrap();
      test_abort();
      test_reset_mid();
`ifdef DMA_FILL_EN
      test_fill();
`endif
      tests++; if (overlap !== 0) begin fails++; $display("FAIL re_we_overlap: got %0d cycles want 0", overlap); end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
